reg_bus_initiator: RTL and testbench
====================================

Name: reg_bus_initiator

Overview:
- Bus initiator (master) for the 19-bit single-cycle register bus used by the accelerator register files.
- Accepts register read/write commands from the control pipeline through a valid/ready command port and buffers them in a small FIFO.
- Issues one bus beat per command beat, with optional address-incrementing bursts.
- Returns read data and write acknowledges through a valid/ready response port with backpressure.

Parameters:
- ADDR_W, 19: bus address width.
- DATA_W, 19: bus data width.
- FIFO_DEPTH, 4: command FIFO entries; power of two, at least 2.
- ADDR_STRIDE, 4: address increment between burst beats (word-aligned bus).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  first beat address.
- cmd_wdata  in  DATA_W  write data, replicated on every write beat (bank fill).
- cmd_len  in  2  beats minus 1 (1..4 beats).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data; 0 for write ack.
- rsp_last  out  1  final response of the command.
- bus_valid  out  1  bus access strobe.
- bus_write  out  1  bus direction.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_rdata  in  DATA_W  combinational read data from responder, valid in the same cycle as bus_valid.
- busy  out  1  state != IDLE or FIFO not empty.

Behaviour:
- Reset and clock: rst_n asynchronous, active-low; clk is the clock.
- Reset values: FIFO empty; state IDLE; all working registers 0.
  - Output values in reset: cmd_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_last = 0, bus_valid = 0, bus_write = 0, bus_addr = 0, bus_wdata = 0, busy = 0.
- FIFO: push on cmd_valid && cmd_ready. cmd_ready = !full, independent of a same-cycle pop (no bypass).
  - Simultaneous push and pop when neither full nor empty: occupancy unchanged, order preserved.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if FIFO not empty, pop the head into working regs (write, addr, wdata, beats_left = len), then go to ACCESS. Otherwise stay.
  - ACCESS: bus_valid = 1 for exactly one cycle per beat.
    - bus_write, bus_addr and bus_wdata come directly from the working regs (registered, glitch-free).
  - ACCESS, read beat: capture bus_rdata into rsp_rdata at the end of the cycle. Set rsp_last = (beats_left == 0) and go to RESP.
  - ACCESS, write beat, beats_left != 0: addr += ADDR_STRIDE, beats_left -= 1, stay in ACCESS (back-to-back bus writes).
  - ACCESS, write beat, beats_left == 0: rsp_rdata = 0, rsp_last = 1, go to RESP. A write command produces exactly one response.
  - RESP: rsp_valid = 1. rsp_rdata and rsp_last stay stable until rsp_ready. No bus activity.
    - On handshake with rsp_last = 0: addr += ADDR_STRIDE, beats_left -= 1, go to ACCESS.
    - On handshake with rsp_last = 1: go to IDLE.
- Latency:
  - Command handshake in cycle 0 into an idle, empty block: pop at the end of cycle 1, bus_valid in cycle 2, rsp_valid in cycle 3.
  - Read burst: minimum 2 cycles per beat.
  - Write burst: 1 cycle per beat, plus 1 ack cycle.
- Address arithmetic: modulo 2^ADDR_W; 0x7FFFC + 4 wraps to 0x00000. Low address bits pass through unmodified.
- bus_valid is never asserted outside ACCESS. Every beat performs exactly one bus access; no retries.
- Reset mid-burst: bus_valid drops immediately (async); the pending response and all queued commands are discarded.

Test Plan:
- Write 0x1234 to 0x00008, len 0 -> bus_valid one cycle in cycle 2 with bus_write = 1, addr 0x00008, wdata 0x1234. rsp_valid in cycle 3 with rdata 0, last 1.
- Read 0x00004, len 0, responder returns 0x5A5A5 -> bus_valid with bus_write = 0 for one cycle. rsp_rdata = 0x5A5A5, rsp_last = 1.
- Read burst 0x00000, len 3, rsp_ready low for 3 cycles on beat 1 -> bus addrs 0x0, 0x4, 0x8, 0xC in order, one access each.
  - Response held stable while stalled, no extra bus_valid; rsp_last only on the 4th response.
- Write fill 0x7FFF8, len 2, data 0x7FFFF -> consecutive bus writes to 0x7FFF8, 0x7FFFC, 0x00000. One ack.
- Push 5 commands with rsp_ready = 0 -> cmd_ready low once 4 entries are buffered and the first is in RESP. Commands complete in push order after release.
- Assert rst_n low during beat 2 of a read burst with 2 commands queued -> bus_valid and rsp_valid go 0 immediately, cmd_ready = 1, busy = 0.
  - After release, no bus activity until a new command arrives.

Source files
------------

// File: rtl/reg_bus_initiator.sv
// reg_bus_initiator: FIFO-buffered register-bus master with burst support and a valid/ready response port
`timescale 1ns/1ps
module reg_bus_initiator #(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 19,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_STRIDE = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [1:0]        cmd_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_last,
    output logic              bus_valid,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + ADDR_W + DATA_W + 2;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nx;
    logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;
    logic              push, pop, empty;
    logic              h_write;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata;
    logic [1:0]        h_len;
    logic              w_write;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [1:0]        beats_left;
    logic [DATA_W-1:0] rdata_q;
    logic              last_q;

    assign empty     = count == '0;
    assign cmd_ready = count != (PW+1)'(FIFO_DEPTH);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = state == IDLE && !empty;
    assign {h_write, h_addr, h_wdata, h_len} = fifo_mem[rd_ptr];

    assign bus_valid = state == ACCESS;
    assign bus_write = w_write;
    assign bus_addr  = w_addr;
    assign bus_wdata = w_wdata;
    assign rsp_valid = state == RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_last  = last_q;
    assign busy      = state != IDLE || !empty;

    // command storage; entries need no reset since occupancy is tracked separately
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata, cmd_len};
    end

    // FIFO pointers and occupancy; push and pop in the same cycle cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    // next state: reads pause in RESP every beat, writes stream and ack once
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = empty ? IDLE : ACCESS;
            ACCESS:  state_nx = (w_write && beats_left != 2'd0) ? ACCESS : RESP;
            RESP:    state_nx = !rsp_ready ? RESP : (last_q ? IDLE : ACCESS);
            default: state_nx = IDLE;
        endcase
    end

    // working registers: load on pop, advance address per beat, capture response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_write    <= 1'b0;
            w_addr     <= '0;
            w_wdata    <= '0;
            beats_left <= '0;
            rdata_q    <= '0;
            last_q     <= 1'b0;
        end else begin
            if (pop) begin
                w_write    <= h_write;
                w_addr     <= h_addr;
                w_wdata    <= h_wdata;
                beats_left <= h_len;
            end
            if (state == ACCESS) begin
                if (w_write && beats_left != 2'd0) begin
                    w_addr     <= w_addr + ADDR_W'(ADDR_STRIDE);
                    beats_left <= beats_left - 2'd1;
                end else begin
                    rdata_q <= w_write ? '0 : bus_rdata;
                    last_q  <= w_write || beats_left == 2'd0;
                end
            end
            if (state == RESP && rsp_ready && !last_q) begin
                w_addr     <= w_addr + ADDR_W'(ADDR_STRIDE);
                beats_left <= beats_left - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_reg_bus_initiator.sv
// tb_reg_bus_initiator: directed and random commands checked against a transaction-level model
`timescale 1ns/1ps
module tb_reg_bus_initiator;
    localparam int AW = 19;
    localparam int DW = 19;

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;
    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [1:0]    cmd_len;
    logic          rsp_valid, rsp_ready, rsp_last;
    logic [DW-1:0] rsp_rdata;
    logic          bus_valid, bus_write;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata, bus_rdata;
    logic          busy;

    beat_t         exp_bus[$];
    rsp_t          exp_rsp[$];
    int            checks = 0;
    int            errors = 0;
    int            bus_beats = 0;
    int            rsp_hs = 0;
    int            rr_mode = 1;
    logic [AW-1:0] last_bus_addr = '0;

    reg_bus_initiator dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
        .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // responder register file: address-dependent contents, 0x00004 holds 0x5A5A5
    function automatic logic [DW-1:0] rd_fn(input logic [AW-1:0] a);
        return (a == 19'h00004) ? 19'h5A5A5 : (a ^ 19'h2B3C1) + 19'd17;
    endfunction

    assign bus_rdata = rd_fn(bus_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: a command expands into its beats and responses
    task automatic model_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] len);
        logic [AW-1:0] ai;
        for (int i = 0; i <= int'(len); i++) begin
            ai = a + AW'(i * 4);
            exp_bus.push_back('{w, ai, d});
            if (!w) exp_rsp.push_back('{rd_fn(ai), i == int'(len)});
        end
        if (w) exp_rsp.push_back('{'0, 1'b1});
    endtask

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] len);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_len   = len;
        @(negedge clk);
        while (!cmd_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("cmd_accept", 32'(cmd_ready), 32'd1);
        if (cmd_ready) model_cmd(w, a, d, len);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 50);
        chk("rsp_wait", 32'(rsp_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_rsp.size() != 0) && n < 3000);
        chk("idle_wait", 32'(n < 3000), 32'd1);
        chk("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // response consumer: 0 = stall, 1 = always ready, 2 = random backpressure
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            rsp_ready = (rr_mode == 1) || (rr_mode == 2 && $urandom_range(0, 2) != 0);
        end
    end

    // compare process: every bus beat and every response against the model
    initial begin
        logic          stall = 1'b0;
        logic [DW-1:0] held_d = '0;
        logic          held_l = 1'b0;
        beat_t         eb;
        rsp_t          er;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall = 1'b0;
                continue;
            end
            if (bus_valid && rsp_valid) chk("bus_during_resp", 32'd1, 32'd0);
            if (bus_valid) begin
                bus_beats++;
                last_bus_addr = bus_addr;
                if (exp_bus.size() == 0) chk("bus_extra", 32'(bus_addr), 32'hFFFF_FFFF);
                else begin
                    eb = exp_bus.pop_front();
                    chk("bus_write", 32'(bus_write), 32'(eb.w));
                    chk("bus_addr", 32'(bus_addr), 32'(eb.a));
                    if (eb.w) chk("bus_wdata", 32'(bus_wdata), 32'(eb.d));
                end
            end
            if (stall) begin
                chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
                if (rsp_valid) begin
                    chk("rsp_hold_rdata", 32'(rsp_rdata), 32'(held_d));
                    chk("rsp_hold_last", 32'(rsp_last), 32'(held_l));
                end
            end
            stall = rsp_valid && !rsp_ready;
            held_d = rsp_rdata;
            held_l = rsp_last;
            if (rsp_valid && rsp_ready) begin
                rsp_hs++;
                if (exp_rsp.size() == 0) chk("rsp_extra", 32'(rsp_rdata), 32'hFFFF_FFFF);
                else begin
                    er = exp_rsp.pop_front();
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(er.d));
                    chk("rsp_last", 32'(rsp_last), 32'(er.l));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, h0, n;
        logic [AW-1:0] a;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_len   = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_last", 32'(rsp_last), 32'd0);
        chk("rst_bus_valid", 32'(bus_valid), 32'd0);
        chk("rst_bus_write", 32'(bus_write), 32'd0);
        chk("rst_bus_addr", 32'(bus_addr), 32'd0);
        chk("rst_bus_wdata", 32'(bus_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // single write: cycle-exact latency
        send(1'b1, 19'h00008, 19'h01234, 2'd0);
        @(negedge clk);
        chk("t1_c1_bus_valid", 32'(bus_valid), 32'd0);
        @(negedge clk);
        chk("t1_c2_bus_valid", 32'(bus_valid), 32'd1);
        chk("t1_c2_bus_write", 32'(bus_write), 32'd1);
        chk("t1_c2_bus_addr", 32'(bus_addr), 32'h00008);
        chk("t1_c2_bus_wdata", 32'(bus_wdata), 32'h01234);
        @(negedge clk);
        chk("t1_c3_bus_valid", 32'(bus_valid), 32'd0);
        chk("t1_c3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_c3_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("t1_c3_rsp_last", 32'(rsp_last), 32'd1);
        @(posedge clk);
        #1;
        wait_idle();

        // single read
        send(1'b0, 19'h00004, 19'h03333, 2'd0);
        wait_rsp();
        chk("t2_rsp_rdata", 32'(rsp_rdata), 32'h5A5A5);
        chk("t2_rsp_last", 32'(rsp_last), 32'd1);
        wait_idle();

        // read burst with a stalled first response
        rr_mode = 0;
        b0 = bus_beats;
        send(1'b0, 19'h00000, 19'h0, 2'd3);
        wait_rsp();
        chk("t3_first_last", 32'(rsp_last), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t3_stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("t3_stall_bus_valid", 32'(bus_valid), 32'd0);
        end
        rr_mode = 1;
        wait_idle();
        chk("t3_beats", 32'(bus_beats - b0), 32'd4);
        chk("t3_last_addr", 32'(last_bus_addr), 32'h0000C);

        // write fill wrapping past the top of the address space
        b0 = bus_beats;
        h0 = rsp_hs;
        send(1'b1, 19'h7FFF8, 19'h7FFFF, 2'd2);
        wait_idle();
        chk("t4_beats", 32'(bus_beats - b0), 32'd3);
        chk("t4_last_addr", 32'(last_bus_addr), 32'h00000);
        chk("t4_acks", 32'(rsp_hs - h0), 32'd1);

        // fill the FIFO behind a stalled response
        rr_mode = 0;
        h0 = rsp_hs;
        for (int i = 0; i < 5; i++) send(1'b0, AW'(32'h40 + 4 * i), 19'h0, 2'd0);
        @(negedge clk);
        chk("t5_cmd_ready_full", 32'(cmd_ready), 32'd0);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t5_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rr_mode = 1;
        wait_idle();
        chk("t5_rsps", 32'(rsp_hs - h0), 32'd5);

        // reset during beat 2 of a read burst with two commands queued
        send(1'b0, 19'h00100, 19'h0, 2'd3);
        send(1'b1, 19'h00200, 19'h00005, 2'd1);
        send(1'b0, 19'h00300, 19'h0, 2'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus_valid && bus_addr == 19'h00104) && n < 50);
        chk("t6_beat2_seen", 32'(n < 50), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_bus_valid", 32'(bus_valid), 32'd0);
        chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t6_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        exp_bus.delete();
        exp_rsp.delete();
        b0 = bus_beats;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("t6_no_activity", 32'(bus_beats - b0), 32'd0);
        chk("t6_idle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // random commands with random backpressure
        rr_mode = 2;
        repeat (80) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) begin
                @(posedge clk);
                #1;
            end
            a = AW'($urandom());
            if ($urandom_range(0, 2) == 0) a[AW-1:4] = '1;
            send(1'($urandom_range(0, 1)), a, DW'($urandom()), 2'($urandom_range(0, 3)));
        end
        rr_mode = 1;
        wait_idle();
        chk("end_rsp_queue", 32'(exp_rsp.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
